serial_rx_lanes: RTL and testbench

SERIAL_RX_LANES -- requirements
Module: serial_rx_lanes

---
 rtl/serial_rx_lanes.sv | 148 ++++++++++++++
 tb/tb_serial_rx_lanes.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_lanes.sv
// Serial receiver: finds comma alignment in a 1-bit stream, locks after LOCK_COUNT
// aligned commas, then deals data symbols round-robin onto LANES output lanes.
// Optional macro SERIAL_RX_LOSS_DETECT_EN adds a MAX_RUN data-run watchdog with lock_lost.
module serial_rx_lanes #(
    parameter int                 WIDTH      = 8,
    parameter int                 LANES      = 4,
    parameter logic [WIDTH-1:0]   COMMA      = WIDTH'(8'hBC),
    parameter int                 LOCK_COUNT = 4,
    parameter int                 MAX_RUN    = 64
) (
    input  logic                     clk_32f,
    input  logic                     reset,
    input  logic                     data_in,
    output logic [LANES*WIDTH-1:0]   lane_data,
    output logic [LANES-1:0]         lane_valid,
    output logic                     active,
    output logic                     lock_lost,
    output logic [1:0]               state_dbg
);

    // Output protocol: lane_valid[i] is a one-cycle strobe with no back-pressure.
    // lane_data[i] is valid while lane_valid[i] is high and holds until lane i strobes again.

    localparam int BW = $clog2(WIDTH);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  sr;
    logic [BW-1:0]     bit_cnt;
    logic [3:0]        comma_cnt;
    logic [PW-1:0]     ptr;
    logic              boundary;
    logic              is_comma;
    logic [BW-1:0]     bit_cnt_next;
    logic [PW-1:0]     ptr_next;

`ifdef SERIAL_RX_LOSS_DETECT_EN
    localparam int RW = $clog2(MAX_RUN + 1);
    logic [RW-1:0]     run_cnt;
`else
    assign lock_lost = 1'b0;
`endif

    // sr holds a complete symbol in the cycle where bit_cnt reaches WIDTH-1.
    assign boundary     = (bit_cnt == BW'(WIDTH - 1));
    assign is_comma     = (sr == COMMA);
    assign bit_cnt_next = boundary ? '0 : bit_cnt + 1'b1;
    assign ptr_next     = (ptr == PW'(LANES - 1)) ? '0 : ptr + 1'b1;
    assign state_dbg    = state;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= SEARCH;
            sr         <= '0;
            bit_cnt    <= '0;
            comma_cnt  <= '0;
            ptr        <= '0;
            lane_data  <= '0;
            lane_valid <= '0;
            active     <= 1'b0;
`ifdef SERIAL_RX_LOSS_DETECT_EN
            run_cnt    <= '0;
            lock_lost  <= 1'b0;
`endif
        end else begin
            sr         <= {sr[WIDTH-2:0], data_in};
            lane_valid <= '0;
`ifdef SERIAL_RX_LOSS_DETECT_EN
            lock_lost  <= 1'b0;
`endif
            case (state)
                SEARCH: begin
                    bit_cnt <= '0;
                    if (is_comma) begin
                        comma_cnt <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end

                SYNC: begin
                    bit_cnt <= bit_cnt_next;
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt <= comma_cnt + 4'd1;
                            if (comma_cnt == 4'(LOCK_COUNT - 1)) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            comma_cnt <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    bit_cnt <= bit_cnt_next;
                    if (boundary) begin
                        if (is_comma) begin
                            ptr <= '0;
`ifdef SERIAL_RX_LOSS_DETECT_EN
                            run_cnt <= '0;
`endif
                        end else begin
`ifdef SERIAL_RX_LOSS_DETECT_EN
                            // A symbol that would push the run past MAX_RUN is dropped, not delivered.
                            if (run_cnt == RW'(MAX_RUN)) begin
                                state     <= SEARCH;
                                active    <= 1'b0;
                                lock_lost <= 1'b1;
                                ptr       <= '0;
                                comma_cnt <= '0;
                                run_cnt   <= '0;
                            end else begin
                                lane_data[int'(ptr)*WIDTH +: WIDTH] <= sr;
                                lane_valid[ptr]                      <= 1'b1;
                                ptr                                  <= ptr_next;
                                run_cnt                              <= run_cnt + 1'b1;
                            end
`else
                            lane_data[int'(ptr)*WIDTH +: WIDTH] <= sr;
                            lane_valid[ptr]                      <= 1'b1;
                            ptr                                  <= ptr_next;
`endif
                        end
                    end
                end

                default: begin
                    state  <= SEARCH;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_lanes.sv
// Bench for serial_rx_lanes: serial stimulus tasks, an expected-symbol queue drained
// by a negedge monitor that checks lane, data, hold behaviour and exact latency.
module tb_serial_rx_lanes;

    localparam int             W          = 8;
    localparam int             LANES      = 4;
    localparam logic [W-1:0]   COMMA      = 8'hBC;
    localparam int             LOCK_COUNT = 4;
    localparam int             MAX_RUN    = 4;
    localparam int             EW         = 16 + 4 + W;

    logic                   clk;
    logic                   reset;
    logic                   data_in;
    logic [LANES*W-1:0]     lane_data;
    logic [LANES-1:0]       lane_valid;
    logic                   active;
    logic                   lock_lost;
    logic [1:0]             state_dbg;

    int                     checks;
    int                     errors;
    int                     cyc;
    int                     exp_ptr;
    int                     lost_cnt;
    logic [EW-1:0]          exp_q[$];
    logic [LANES*W-1:0]     model_data;
    logic [EW-1:0]          mon_e;
    logic [LANES-1:0]       mon_vec;
    int                     mon_lane;

    serial_rx_lanes #(
        .WIDTH      (W),
        .LANES      (LANES),
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_RUN    (MAX_RUN)
    ) dut (
        .clk_32f    (clk),
        .reset      (reset),
        .data_in    (data_in),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .active     (active),
        .lock_lost  (lock_lost),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (lock_lost === 1'b1) lost_cnt++;
            if (lane_valid !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: lane_valid=%b lane_data=%h, nothing expected", lane_valid, lane_data);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_lane = int'(mon_e[W+3:W]);
                    model_data[mon_lane*W +: W] = mon_e[W-1:0];
                    mon_vec  = '0;
                    mon_vec[mon_lane] = 1'b1;
                    if (lane_valid !== mon_vec || lane_data !== model_data || cyc != int'(mon_e[EW-1:W+4])) begin
                        errors++;
                        $display("FAIL lane_output: got valid=%b data=%h cycle=%0d, want valid=%b data=%h cycle=%0d",
                                 lane_valid, lane_data, cyc, mon_vec, model_data, int'(mon_e[EW-1:W+4]));
                    end
                end
            end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][EW-1:W+4])) begin
                checks++;
                errors++;
                mon_e = exp_q.pop_front();
                $display("FAIL missing_valid: got no strobe by cycle %0d, want lane %0d data %h",
                         cyc, int'(mon_e[W+3:W]), mon_e[W-1:0]);
            end
        end
    end

    // driver tasks
    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in = b;
    endtask

    task automatic send_sym(input logic [W-1:0] s, input bit deliver);
        for (int i = W - 1; i >= 0; i--) send_bit(s[i]);
        if (deliver) begin
            exp_q.push_back({16'(cyc + 2), 4'(exp_ptr), s});
            exp_ptr = (exp_ptr + 1) % LANES;
        end
    endtask

    task automatic send_comma();
        send_sym(COMMA, 1'b0);
        exp_ptr = 0;
    endtask

    task automatic do_lock();
        for (int i = 0; i < LOCK_COUNT; i++) send_comma();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        model_data = '0;
        exp_ptr    = 0;
        lost_cnt   = 0;
    endtask

    task automatic drain(input string name);
        send_comma();
        send_comma();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d symbols still pending, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // tests
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (lane_data !== '0) begin
            errors++;
            $display("FAIL reset_lane_data: got %h want 0", lane_data);
        end
        checks++;
        if (lane_valid !== '0) begin
            errors++;
            $display("FAIL reset_lane_valid: got %b want 0", lane_valid);
        end
        check_bit("reset_active", active, 1'b0);
        check_bit("reset_lock_lost", lock_lost, 1'b0);
        reset = 1'b0;
        repeat (12) send_bit(1'b0);
        check_bit("idle_zeros_active", active, 1'b0);
    endtask

    task automatic test_basic_lanes();
        do_reset();
        do_lock();
        send_sym(8'h11, 1'b1);
        check_bit("lock_active", active, 1'b1);
        send_sym(8'h22, 1'b1);
        send_sym(8'h33, 1'b1);
        send_sym(8'h44, 1'b1);
        drain("basic_lanes");
    endtask

    task automatic test_comma_resets_ptr();
        do_reset();
        do_lock();
        send_sym(8'hAA, 1'b1);
        send_sym(8'hBB, 1'b1);
        send_comma();
        send_sym(8'hCC, 1'b1);
        drain("comma_ptr");
        check_bit("comma_ptr_active", active, 1'b1);
    endtask

    task automatic test_short_lock();
        do_reset();
        for (int i = 0; i < LOCK_COUNT - 1; i++) send_comma();
        send_sym(8'h55, 1'b0);
        repeat (6) send_bit(1'b0);
        check_bit("short_lock_active", active, 1'b0);
        do_lock();
        send_sym(8'h66, 1'b1);
        drain("short_lock_relock");
    endtask

    task automatic test_random_align();
        logic [W-1:0] d;
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        do_lock();
        send_sym(8'h5A, 1'b1);
        send_comma();
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                d = W'($urandom_range(0, 255));
                if (d == COMMA) d = d ^ 8'h01;
                send_sym(d, 1'b1);
            end
            send_comma();
        end
        drain("random_align");
    endtask

    task automatic test_reset_mid_symbol();
        do_reset();
        do_lock();
        send_sym(8'h12, 1'b1);
        send_comma();
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (lane_valid !== '0 || lane_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got valid=%b data=%h want 0", lane_valid, lane_data);
        end
        check_bit("mid_reset_active", active, 1'b0);
        check_bit("mid_reset_lock_lost", lock_lost, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        model_data = '0;
        exp_ptr    = 0;
        for (int i = 0; i < LOCK_COUNT - 1; i++) send_comma();
        send_bit(1'b0);
        check_bit("mid_reset_partial_relock_active", active, 1'b0);
        send_bit(1'b0);
        repeat (6) send_bit(1'b0);
        do_lock();
        send_sym(8'h77, 1'b1);
        check_bit("mid_reset_relock_active", active, 1'b1);
        drain("mid_reset");
    endtask

    task automatic test_run_limit();
        bit loss;
`ifdef SERIAL_RX_LOSS_DETECT_EN
        loss = 1'b1;
`else
        loss = 1'b0;
`endif
        do_reset();
        do_lock();
        send_sym(8'h01, 1'b1);
        send_sym(8'h02, 1'b1);
        send_sym(8'h03, 1'b1);
        send_sym(8'h04, 1'b1);
        send_sym(8'h05, !loss);
        fork
            send_comma();
            begin
                repeat (2) @(negedge clk);
                check_bit("run_limit_active", active, !loss);
                check_bit("run_limit_lock_lost", lock_lost, loss);
            end
        join
        drain("run_limit");
        checks++;
        if (lost_cnt != int'(loss)) begin
            errors++;
            $display("FAIL run_limit_pulses: got %0d lock_lost cycles want %0d", lost_cnt, int'(loss));
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_ptr    = 0;
        lost_cnt   = 0;
        model_data = '0;
        reset      = 1'b1;
        data_in    = 1'b0;
        test_reset();
        test_basic_lanes();
        test_comma_resets_ptr();
        test_short_lock();
        test_random_align();
        test_reset_mid_symbol();
        test_run_limit();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
